echo_indication_proxy: RTL

Downstream stage of the echo block. Consumes ind_echo method calls (32-bit payload), buffers them in a small FIFO, and serialises each into a two-word indication message (header, payload) on a valid/ready word stream toward the host portal. Provides backpressure to the echo block via ind_echo__RDY, plus sticky overflow and message-count status.

---
 rtl/echo_indication_proxy_if.sv | 49 ++++
 rtl/echo_indication_proxy.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/echo_indication_proxy_if.sv
// -----------------------------------------------------------------------------
// echo_indication_proxy_if
//   Bundles the two handshakes of the echo indication proxy:
//     - ind_echo method call from the echo block (ENA strobe, 32-bit payload,
//       RDY backpressure);
//     - the outgoing message word stream toward the host portal
//       (out_valid / out_ready / out_data / out_last).
//
//   Handshake rules, for both channels:
//     A transfer happens at a rising CLK edge exactly when the source's
//     strobe (ind_echo__ENA / out_valid) and the sink's ready
//     (ind_echo__RDY / out_ready) are both high. While out_valid is high
//     and out_ready is low, out_data and out_last hold their values.
//     ind_echo__ENA may be raised regardless of ind_echo__RDY; a strobe
//     without RDY is a dropped call and is flagged as an overflow.
//
//   Modports:
//     slave  : the proxy itself (consumes ind_echo, produces message words)
//     master : the environment (echo block + host portal sink)
// -----------------------------------------------------------------------------
interface echo_indication_proxy_if;
  logic        ind_echo__ENA;
  logic [31:0] ind_echo_v;
  logic        ind_echo__RDY;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport slave (
    input  ind_echo__ENA,
    input  ind_echo_v,
    input  out_ready,
    output ind_echo__RDY,
    output out_valid,
    output out_data,
    output out_last
  );

  modport master (
    output ind_echo__ENA,
    output ind_echo_v,
    output out_ready,
    input  ind_echo__RDY,
    input  out_valid,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/echo_indication_proxy.sv
// -----------------------------------------------------------------------------
// echo_indication_proxy
//   Downstream stage of the echo block. Buffers ind_echo payloads in a small
//   FIFO and serialises each one into a two-word message:
//     word 0 (header)  : {METHOD_ID, MSG_LEN}, out_last = 0
//     word 1 (payload) : the 32-bit payload,   out_last = 1
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   nRST         synchronous active-low reset
//   bus          echo_indication_proxy_if.slave (ind_echo call + word stream)
//   occupancy    FIFO entries currently held, 0..DEPTH
//   err_overflow sticky flag: a call was strobed while RDY was low
//   msg_count    completed messages, wraps modulo 2^16
//   state_dbg    current FSM state (0 IDLE, 1 HDR, 2 DATA)
//
// Parameters:
//   DEPTH      FIFO entries, power of two and at least 2
//   METHOD_ID  header bits [31:16]
//   MSG_LEN    header bits [15:0]
// -----------------------------------------------------------------------------
module echo_indication_proxy #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] METHOD_ID = 16'h0001,
  parameter logic [15:0] MSG_LEN   = 16'd2
) (
  input  logic                      CLK,
  input  logic                      nRST,
  echo_indication_proxy_if.slave    bus,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      err_overflow,
  output logic [15:0]               msg_count,
  output logic [1:0]                state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [31:0] HEADER_WORD = {METHOD_ID, MSG_LEN};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [31:0]        mem_q [DEPTH];
  logic [31:0]        mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [OCC_W-1:0]   occ_q,       occ_d;
  logic [31:0]        payload_q,   payload_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q,  out_data_d;
  logic               out_last_q,  out_last_d;
  logic               err_q,       err_d;
  logic [15:0]        msg_count_q, msg_count_d;

  logic               rdy;
  logic               push;
  logic               pop;
  logic [31:0]        head;

  // RDY looks only at registered occupancy: a pop in the same cycle does not
  // free a slot for a simultaneous push when the FIFO is full.
  assign rdy  = nRST && (occ_q != OCC_W'(DEPTH));
  assign push = bus.ind_echo__ENA && rdy;
  assign head = mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    payload_d   = payload_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    msg_count_d = msg_count_q;
    pop         = 1'b0;

    // Enqueue side
    if (push) begin
      mem_d[wr_ptr_q] = bus.ind_echo_v;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    // A strobe with no room is a lost call; remember it until reset.
    if (bus.ind_echo__ENA && !rdy && nRST) begin
      err_d = 1'b1;
    end

    // Serialiser. Outputs are registered: each branch loads the word that
    // belongs to the state being entered, so out_* always match state_q.
    // Pops test occ_q, so an entry pushed this cycle is never popped until
    // the next one.
    case (state_q)
      S_IDLE: begin
        if (occ_q != '0) begin
          pop         = 1'b1;
          payload_d   = head;
          state_d     = S_HDR;
          out_valid_d = 1'b1;
          out_data_d  = HEADER_WORD;
          out_last_d  = 1'b0;
        end
      end

      S_HDR: begin
        if (bus.out_ready) begin
          state_d     = S_DATA;
          out_valid_d = 1'b1;
          out_data_d  = payload_q;
          out_last_d  = 1'b1;
        end
      end

      S_DATA: begin
        if (bus.out_ready) begin
          msg_count_d = msg_count_q + 16'd1;
          if (occ_q != '0) begin
            // Chain straight into the next header: no idle bubble.
            pop         = 1'b1;
            payload_d   = head;
            state_d     = S_HDR;
            out_valid_d = 1'b1;
            out_data_d  = HEADER_WORD;
            out_last_d  = 1'b0;
          end else begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;
      end
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Push and pop together leave occupancy unchanged.
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      payload_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      msg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      payload_q   <= payload_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      msg_count_q <= msg_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ind_echo__RDY = rdy;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_last      = out_last_q;
  assign occupancy         = occ_q;
  assign err_overflow      = err_q;
  assign msg_count         = msg_count_q;
  assign state_dbg         = state_q;

endmodule
